// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the core-side UART word bridge.
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } bridge_state_t;

    localparam logic RORS_SEND = 1'b1;
    localparam logic RORS_RECV = 1'b0;

endpackage

// File: rtl/uart_word_bridge.sv
// Splits one core byte/word IO request into single-byte UART go/done transactions.
// Define UART_BIG_ENDIAN_EN to put the most significant byte first on the wire in word mode.
module uart_word_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic                    req_word,
    input  logic [8*WORD_BYTES-1:0] req_wdata,
    output logic                    resp_valid,
    output logic [8*WORD_BYTES-1:0] resp_rdata,
    output logic                    uart_go,
    output logic                    rors,
    output logic [7:0]              txdata,
    input  logic                    uart_done,
    input  logic [7:0]              rxdata
);

    localparam int unsigned DW = 8 * WORD_BYTES;
    localparam int unsigned CW = $clog2(WORD_BYTES);

    bridge_state_t   state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            word_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   buf_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic            uart_go_q;
    logic            rors_q;
    logic [7:0]      txdata_q;

    logic [CW-1:0]   cur_lane;
    logic [CW-1:0]   nxt_lane;
    logic [CW-1:0]   first_lane;
    logic [CW-1:0]   last_cnt;

    // Maps transfer index to byte lane; byte mode always resolves to lane 0.
    function automatic logic [CW-1:0] lane_of(input logic word, input logic [CW-1:0] k);
`ifdef UART_BIG_ENDIAN_EN
        return word ? (CW'(WORD_BYTES - 1) - k) : k;
`else
        return k;
`endif
    endfunction

    always_comb begin
        cnt_d      = cnt_q + 1'b1;
        cur_lane   = lane_of(word_q, cnt_q);
        nxt_lane   = lane_of(word_q, cnt_d);
        first_lane = lane_of(req_word, '0);
        last_cnt   = word_q ? CW'(WORD_BYTES - 1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            word_q       <= 1'b0;
            wdata_q      <= '0;
            buf_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            uart_go_q    <= 1'b0;
            rors_q       <= RORS_RECV;
            txdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rors_q      <= req_write ? RORS_SEND : RORS_RECV;
                        word_q      <= req_word;
                        wdata_q     <= req_wdata;
                        cnt_q       <= '0;
                        buf_q       <= '0;
                        txdata_q    <= req_wdata[8*first_lane +: 8];
                        req_ready_q <= 1'b0;
                        uart_go_q   <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    uart_go_q <= 1'b0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (uart_done) begin
                        if (rors_q == RORS_RECV) begin
                            buf_q[8*cur_lane +: 8] <= rxdata;
                        end
                        if (cnt_q == last_cnt) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            // Next byte is staged here so go fires the cycle after done.
                            cnt_q     <= cnt_d;
                            txdata_q  <= wdata_q[8*nxt_lane +: 8];
                            uart_go_q <= 1'b1;
                            state_q   <= ISSUE;
                        end
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = buf_q;
    assign uart_go    = uart_go_q;
    assign rors       = rors_q;
    assign txdata     = txdata_q;

endmodule

// File: tb/tb_uart_word_bridge.sv
// Randomized bench for uart_word_bridge with an inline UART responder and reference model.
module tb_uart_word_bridge;

    localparam int WB = 4;
`ifdef UART_BIG_ENDIAN_EN
    localparam bit BIG = 1'b1;
`else
    localparam bit BIG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic          req_word;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          uart_go;
    logic          rors;
    logic [7:0]    txdata;
    logic          uart_done;
    logic [7:0]    rxdata;

    int checks   = 0;
    int failures = 0;

    uart_word_bridge #(.WORD_BYTES(WB)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_word   (req_word),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .uart_go    (uart_go),
        .rors       (rors),
        .txdata     (txdata),
        .uart_done  (uart_done),
        .rxdata     (rxdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Wire order: transfer k carries lane k, or lane WB-1-k for big-endian words.
    function automatic int lane_of(input bit word, input int k);
        return (word && BIG) ? (WB - 1 - k) : k;
    endfunction

    task automatic scramble_req();
        req_write = 1'($urandom);
        req_word  = 1'($urandom);
        req_wdata = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, req_ready, 1);
        check_eq({tag, "_resp"},  resp_valid, 0);
        check_eq({tag, "_rdata"}, resp_rdata, 0);
        check_eq({tag, "_go"},    uart_go, 0);
        check_eq({tag, "_rors"},  rors, 0);
        check_eq({tag, "_tx"},    txdata, 0);
    endtask

    // Runs one request end to end, playing the UART side with fixed done latency.
    task automatic run_txn(input bit wr, input bit word, input logic [31:0] wdata,
                           input logic [31:0] rxw, input int dly, input bit hold,
                           input bit spur, input int abort_k);
        int          n;
        int          l;
        int          waitc;
        logic [31:0] exp_rd;
        logic [7:0]  exp_tx;
        n      = word ? WB : 1;
        exp_rd = '0;
        waitc  = 0;
        while (req_ready !== 1'b1 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check_eq("accept_ready", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_word  = word;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            l      = lane_of(word, k);
            exp_tx = wdata[8*l +: 8];
            check_eq("go_pulse", uart_go, 1);
            check_eq("rors_go", rors, wr);
            check_eq("tx_go", txdata, exp_tx);
            check_eq("ready_busy", req_ready, 0);
            check_eq("resp_quiet", resp_valid, 0);
            if (hold) scramble_req();
            else req_valid = 1'b0;
            if (spur) begin
                uart_done = 1'b1;
                rxdata    = 8'($urandom);
            end
            for (int i = 1; i <= dly; i++) begin
                @(negedge clk);
                uart_done = 1'b0;
                if (hold) scramble_req();
                if (k == abort_k && i == 1) begin
                    rst = 1'b1;
                    req_valid = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    check_reset_outputs("abort");
                    return;
                end
                check_eq("go_low", uart_go, 0);
                check_eq("tx_hold", txdata, exp_tx);
                check_eq("rors_hold", rors, wr);
                check_eq("ready_wait", req_ready, 0);
                check_eq("resp_wait", resp_valid, 0);
                if (i == dly) begin
                    uart_done = 1'b1;
                    rxdata    = rxw[8*k +: 8];
                end
            end
            if (!wr) exp_rd[8*l +: 8] = rxw[8*k +: 8];
            @(negedge clk);
            uart_done = 1'b0;
        end
        check_eq("resp_pulse", resp_valid, 1);
        check_eq("resp_data", resp_rdata, exp_rd);
        check_eq("resp_go", uart_go, 0);
        check_eq("resp_ready", req_ready, 0);
        @(negedge clk);
        check_eq("post_resp", resp_valid, 0);
        check_eq("post_ready", req_ready, 1);
        check_eq("post_data", resp_rdata, exp_rd);
        check_eq("post_go", uart_go, 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_word  = 1'b0;
        req_wdata = '0;
        uart_done = 1'b0;
        rxdata    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Directed scenarios: word send, word receive, byte receive.
        run_txn(1'b1, 1'b1, 32'hA1B2C3D4, 32'h0, 5, 1'b0, 1'b0, -1);
        run_txn(1'b0, 1'b1, 32'h0, 32'h44332211, 3, 1'b0, 1'b0, -1);
        run_txn(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_007F, 2, 1'b0, 1'b0, -1);
        // Request held through a busy transfer with a spurious done in ISSUE.
        run_txn(1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, 2, 1'b1, 1'b1, -1);
        run_txn(1'b1, 1'b0, 32'h0000_005A, 32'h0, 1, 1'b0, 1'b0, -1);
        // Reset during WAIT of the third byte, then a normal byte request.
        run_txn(1'b0, 1'b1, 32'h0, 32'h8877_6655, 3, 1'b0, 1'b0, 2);
        run_txn(1'b0, 1'b0, 32'h0, 32'h0000_00C3, 2, 1'b0, 1'b0, -1);

        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), 1'($urandom), $urandom, $urandom,
                    int'($urandom_range(1, 6)), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0), -1);
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("final_idle_go", uart_go, 0);
        check_eq("final_ready", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_word_bridge.md
Name: uart_word_bridge

Overview:
- Core-side front end for the UART unit. It sits between the core's memory/IO stage and the UART unit's go/done handshake.
- It converts one core IO request (byte or full word, send or receive) into a sequence of 1 or WORD_BYTES single-byte UART transactions.
- It assembles received bytes into a word, and reports completion through a one-cycle response pulse. The core stalls on req_ready/resp_valid.

Parameters:
- WORD_BYTES, 4: bytes per word transfer; data width is 8*WORD_BYTES; must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high, sampled on posedge clk
- req_valid  in  1  core request present
- req_ready  out  1  bridge can accept a request (high only in IDLE)
- req_write  in  1  1 = send to UART, 0 = receive from UART
- req_word  in  1  1 = WORD_BYTES bytes, 0 = single byte
- req_wdata  in  8*WORD_BYTES  send data; byte mode uses bits [7:0]
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  8*WORD_BYTES  received data; 0 for sends
- uart_go  out  1  one-cycle start pulse to UART unit
- rors  out  1  1 = send, 0 = receive; held for whole transaction
- txdata  out  8  byte to send; held from uart_go until uart_done
- uart_done  in  1  one-cycle done pulse from UART unit
- rxdata  in  8  received byte; valid in the cycle uart_done is high

Behaviour:
- Interface rule: one clock clk; reset rst is synchronous and active-high.
- Reset (any state, including mid-transfer):
  - Next state is IDLE; byte counter and data buffer are cleared.
  - Outputs after the reset edge: req_ready=1, resp_valid=0, resp_rdata=0, uart_go=0, rors=0, txdata=0.
  - The UART unit shares the system reset, so no drain is attempted.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_write into rors, latch req_word and req_wdata, set cnt=0, and go to ISSUE.
  - Any request presented outside IDLE is not accepted.
- ISSUE: uart_go=1 for exactly one cycle; go to WAIT.
- WAIT:
  - uart_go=0; hold until uart_done=1.
  - On a receive, write rxdata into byte lane cnt of the buffer.
  - If cnt == last (0 for byte mode, WORD_BYTES-1 for word mode), go to RESP; otherwise cnt++ and go to ISSUE.
  - The next uart_go therefore occurs exactly one cycle after uart_done, when the UART unit is back in IDLE.
- RESP:
  - resp_valid=1 for one cycle; resp_rdata = buffer (byte receive is zero-extended from bits [7:0]; send gives 0).
  - Go to IDLE.
- Output decode:
  - txdata = byte lane cnt of the latched wdata, stable across ISSUE/WAIT.
  - rors is constant between request acceptance and RESP.
- uart_done outside WAIT is ignored; it is a protocol error and is not latched.
- Byte order (default little-endian): transfer k uses bits [8k+7:8k], so k=0 is sent/received first.
- Latency:
  - Accept at cycle 0; first uart_go at cycle 1.
  - resp_valid comes one cycle after the final uart_done.
  - Minimum turnaround between back-to-back requests: RESP to IDLE, then accept in IDLE.
- resp_rdata holds its value after RESP until the next receive writes the buffer; it is cleared on acceptance of a new request.

Optional Feature:
- UART_BIG_ENDIAN_EN.
- Defined: in word mode, transfer k uses byte lane WORD_BYTES-1-k, so the MSB is first on the wire for both send and receive.
- Not defined: little-endian as above.
- Byte mode is identical in both builds.

Decomposition:
- Package uart_bridge_pkg:
  - bridge_state_t enum (IDLE, ISSUE, WAIT, RESP), encoded in logic [1:0].
  - Constants RORS_SEND=1'b1 and RORS_RECV=1'b0.
- No sub-module: lane select/insert is a few lines of indexed part-select inside the block.

Test Plan:
- Word send, WORD_BYTES=4, req_wdata=32'hA1B2C3D4, responder model asserting uart_done 5 cycles after each uart_go -> exactly 4 uart_go pulses with rors=1; txdata sequence D4,C3,B2,A1; each next go exactly 1 cycle after done; one resp_valid with resp_rdata=0. With UART_BIG_ENDIAN_EN the sequence is A1,B2,C3,D4.
- Word receive, responder returning rxdata 11,22,33,44 -> resp_rdata=32'h44332211, or 32'h11223344 with UART_BIG_ENDIAN_EN; resp_valid exactly 1 cycle after the 4th uart_done.
- Byte receive, rxdata=8'h7F with done 2 cycles after go -> accept cycle 0, go cycle 1, done cycle 3, resp_valid cycle 4, resp_rdata=32'h0000007F; req_ready low cycles 1-4.
- req_valid held high through a busy transfer, plus a spurious uart_done injected in ISSUE -> second request accepted only at the next IDLE; spurious done ignored (byte count and data unaffected).
- rst asserted during WAIT of the 3rd byte of a word receive -> after the edge: IDLE, req_ready=1, uart_go=0, resp_valid=0, resp_rdata=0; the next byte request completes normally.
